// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues req/done reads at the PC's address and buffers words for decode.
// Optional stall counter enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] NOP_WORD = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] next_pc,
   input  logic        redirect,
   input  logic        halt,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        pc_advance,
   output logic [15:0] instr,
   output logic [15:0] instr_pc2,
   output logic        instr_valid,
   input  logic        dec_ready,
   output logic        err,
   output logic [15:0] stall_cycles
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_ISSUE  = 2'd0,
      ST_WAIT   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [15:0]   fetch_addr_r, drain_addr_r, mem_addr_s;
   logic          halt_r, err_r, halt_any_s;
   logic          mem_rd_s, push_s, pop_s, adv_s, load_s, drain_load_s, valid_s;
   logic [15:0]   q_data_r [DEPTH];
   logic [15:0]   q_pc2_r  [DEPTH];
   logic [AW-1:0] rd_ptr_r, wr_ptr_r;
   logic [CW-1:0] count_r;

   assign halt_any_s = halt | halt_r;
   assign valid_s    = (count_r != {CW{1'b0}});
   assign pop_s      = valid_s & dec_ready;
   // A discarded read keeps its original address on the bus until the memory completes it.
   assign mem_addr_s = (state_r == ST_DRAIN) ? drain_addr_r : fetch_addr_r;

   // Next-state, request and push/advance decisions
   always_comb begin
      state_s      = state_r;
      mem_rd_s     = 1'b0;
      push_s       = 1'b0;
      adv_s        = 1'b0;
      load_s       = 1'b0;
      drain_load_s = 1'b0;
      if (rst) begin
         state_s = ST_ISSUE;
      end else begin
         case (state_r)
            ST_ISSUE:           mem_rd_s = ~halt_any_s & (count_r < FULL);
            ST_WAIT, ST_DRAIN:  mem_rd_s = 1'b1;
            ST_HALTED:          mem_rd_s = 1'b0;
            default:            mem_rd_s = 1'b0;
         endcase
         if (redirect) begin
            load_s = 1'b1;
            if (mem_rd_s & ~mem_done) begin
               state_s      = ST_DRAIN;
               drain_load_s = 1'b1;
            end else if (halt_any_s) begin
               state_s = ST_HALTED;
            end else begin
               state_s = ST_ISSUE;
            end
         end else if (state_r == ST_DRAIN) begin
            if (mem_done) begin
               state_s = halt_any_s ? ST_HALTED : ST_ISSUE;
            end else begin
               state_s = ST_DRAIN;
            end
         end else if (mem_rd_s & mem_done) begin
            push_s  = 1'b1;
            adv_s   = 1'b1;
            load_s  = 1'b1;
            state_s = halt_any_s ? ST_HALTED : ST_ISSUE;
         end else if (mem_rd_s) begin
            state_s = ST_WAIT;
         end else if (halt_any_s) begin
            state_s = ST_HALTED;
         end else begin
            state_s = state_r;
         end
      end
   end

   // FSM state, fetch address, sticky halt and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_ISSUE;
         fetch_addr_r <= 16'h0000;
         drain_addr_r <= 16'h0000;
         halt_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r <= state_s;
         if (load_s)               fetch_addr_r <= next_pc;
         if (drain_load_s)         drain_addr_r <= mem_addr_s;
         if (halt)                 halt_r       <= 1'b1;
         if (mem_done & ~mem_rd_s) err_r        <= 1'b1;
      end
   end

   // Instruction queue storage and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_data_r[i] <= 16'h0000;
            q_pc2_r[i]  <= 16'h0000;
         end
      end else if (redirect) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            q_data_r[wr_ptr_r] <= mem_rdata;
            q_pc2_r[wr_ptr_r]  <= mem_addr_s + 16'd2;
            wr_ptr_r           <= wr_ptr_r + AW'(1);
         end
         if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign mem_addr    = mem_addr_s;
   assign mem_rd      = mem_rd_s;
   assign pc_advance  = adv_s;
   assign instr_valid = valid_s;
   assign instr       = valid_s ? q_data_r[rd_ptr_r] : NOP_WORD;
   assign instr_pc2   = valid_s ? q_pc2_r[rd_ptr_r]  : 16'h0000;
   assign err         = err_r;

`ifdef FETCH_QUEUE_PERF_EN
   logic [15:0] stall_r;

   // Saturating count of cycles spent waiting on memory or starved of instructions
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r <= 16'h0000;
      end else if (((mem_rd_s & ~mem_done) | (~valid_s & (state_r != ST_HALTED)))
                   && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign stall_cycles = stall_r;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule
